// File: rtl/riscv_pkg.sv
// Opcode constants, register index type and the opcode-to-register-use decode
// shared by the issue stage and its busy scoreboard.
package riscv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic use1;
        logic use2;
        logic wrd;
    } reg_use_t;

    // Unknown opcodes read nothing but still claim rd, so a stray write stays ordered.
    function automatic reg_use_t reg_use(input logic [6:0] opcode);
        reg_use_t u;
        u = '{use1: 1'b0, use2: 1'b0, wrd: 1'b1};
        case (opcode)
            OP:                 begin u.use1 = 1'b1; u.use2 = 1'b1; end
            BRANCH, STORE:      begin u.use1 = 1'b1; u.use2 = 1'b1; u.wrd = 1'b0; end
            OP_IMM, LOAD, JALR: u.use1 = 1'b1;
            default:            ;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// 32-entry busy vector with three lookups qualified by a same-cycle writeback
// when the register file is write-before-read.
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int WB_BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_en,
    input  reg_idx_t    set_idx,
    input  logic        clr_en,
    input  reg_idx_t    clr_idx,
    input  reg_idx_t    a_idx,
    input  reg_idx_t    b_idx,
    input  reg_idx_t    c_idx,
    output logic [31:0] busy,
    output logic        a_bsy,
    output logic        b_bsy,
    output logic        c_bsy
);

    localparam logic BYP = (WB_BYPASS != 0);

    logic [31:0] busy_q, busy_d;
    logic [31:0] set_vec, clr_vec;

    // Set is OR-ed after the clear so a new producer owns the register.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en && set_idx != 5'd0) set_vec = 32'd1 << set_idx;
        if (clr_en)                    clr_vec = 32'd1 << clr_idx;
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy  = busy_q;
    assign a_bsy = busy_q[a_idx] & ~(BYP & clr_en & (clr_idx == a_idx));
    assign b_bsy = busy_q[b_idx] & ~(BYP & clr_en & (clr_idx == b_idx));
    assign c_bsy = busy_q[c_idx] & ~(BYP & clr_en & (clr_idx == c_idx));

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-to-issue stage: one held instruction, RAW/WAW hazard gating against
// the busy scoreboard, flush, and a saturating stall-cycle counter.
module issue_scoreboard
    import riscv_pkg::*;
#(
    parameter int WB_BYPASS = 1,
    parameter int STALL_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [6:0]         id_opcode,
    input  reg_idx_t           id_rd,
    input  reg_idx_t           id_rs1,
    input  reg_idx_t           id_rs2,
    output logic               iss_valid,
    input  logic               iss_ready,
    output logic [6:0]         iss_opcode,
    output reg_idx_t           iss_rd,
    output reg_idx_t           iss_rs1,
    output reg_idx_t           iss_rs2,
    input  logic               wb_valid,
    input  reg_idx_t           wb_rd,
    output logic [31:0]        busy,
    output logic [STALL_W-1:0] stall_cnt
);

    logic               entry_valid_q, entry_valid_d;
    logic [6:0]         opcode_q, opcode_d;
    reg_idx_t           rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    reg_use_t use_q;
    logic     bsy_rs1, bsy_rs2, bsy_rd;
    logic     hazard, issue_fire, load;

    assign use_q = reg_use(opcode_q);

    reg_scoreboard #(.WB_BYPASS(WB_BYPASS)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (issue_fire & use_q.wrd),
        .set_idx (rd_q),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .a_idx   (rs1_q),
        .b_idx   (rs2_q),
        .c_idx   (rd_q),
        .busy    (busy),
        .a_bsy   (bsy_rs1),
        .b_bsy   (bsy_rs2),
        .c_bsy   (bsy_rd)
    );

    // Handshake: a transfer happens on a side only in a cycle where valid and
    // ready are both high. iss_valid never drops without a transfer except on
    // flush, and iss_* are registers so they hold while iss_valid & ~iss_ready.
    // id_ready depends combinationally on iss_ready so the entry can be
    // refilled in the same cycle it issues.
    assign hazard     = (use_q.use1 & bsy_rs1) | (use_q.use2 & bsy_rs2) | (use_q.wrd & bsy_rd);
    assign iss_valid  = entry_valid_q & ~hazard & ~flush;
    assign issue_fire = iss_valid & iss_ready;
    assign id_ready   = ~flush & (~entry_valid_q | issue_fire);
    assign load       = id_valid & id_ready;

    always_comb begin
        entry_valid_d = entry_valid_q;
        opcode_d      = opcode_q;
        rd_d          = rd_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        stall_d       = stall_q;
        if (flush) begin
            entry_valid_d = 1'b0;
        end else if (load) begin
            entry_valid_d = 1'b1;
            opcode_d      = id_opcode;
            rd_d          = id_rd;
            rs1_d         = id_rs1;
            rs2_d         = id_rs2;
        end else if (issue_fire) begin
            entry_valid_d = 1'b0;
        end
        if (entry_valid_q && hazard && !flush && !(&stall_q))
            stall_d = stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_valid_q <= 1'b0;
            opcode_q      <= '0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            stall_q       <= '0;
        end else begin
            entry_valid_q <= entry_valid_d;
            opcode_q      <= opcode_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            stall_q       <= stall_d;
        end
    end

    assign iss_opcode = opcode_q;
    assign iss_rd     = rd_q;
    assign iss_rs1    = rs1_q;
    assign iss_rs2    = rs2_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: one instance with writeback bypass and
// one without, driven by the same inputs, plus a random-backpressure stream.
module tb_issue_scoreboard;
    import riscv_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       id_valid = 1'b0;
    logic [6:0] id_opcode = '0;
    logic [4:0] id_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic       iss_ready = 1'b0;
    logic       wb_valid = 1'b0;
    logic [4:0] wb_rd = '0;

    logic        a_id_ready, a_iss_valid, b_id_ready, b_iss_valid;
    logic [6:0]  a_iss_opcode, b_iss_opcode;
    logic [4:0]  a_iss_rd, a_iss_rs1, a_iss_rs2, b_iss_rd, b_iss_rs1, b_iss_rs2;
    logic [31:0] a_busy, b_busy;
    logic [15:0] a_stall, b_stall;

    int checks = 0;
    int errors = 0;

    logic [21:0] exp_q[$];

    always #5 clk = ~clk;

    issue_scoreboard #(.WB_BYPASS(1), .STALL_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(a_id_ready), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .iss_valid(a_iss_valid), .iss_ready(iss_ready), .iss_opcode(a_iss_opcode),
        .iss_rd(a_iss_rd), .iss_rs1(a_iss_rs1), .iss_rs2(a_iss_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .busy(a_busy), .stall_cnt(a_stall)
    );

    issue_scoreboard #(.WB_BYPASS(0), .STALL_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(b_id_ready), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .iss_valid(b_iss_valid), .iss_ready(iss_ready), .iss_opcode(b_iss_opcode),
        .iss_rd(b_iss_rd), .iss_rs1(b_iss_rs1), .iss_rs2(b_iss_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .busy(b_busy), .stall_cnt(b_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the design samples on the rising edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2);
        id_valid  = v;
        id_opcode = op;
        id_rd     = rd;
        id_rs1    = rs1;
        id_rs2    = rs2;
    endtask

    task automatic writeback(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
        step();
        wb_valid = 1'b0;
        wb_rd    = '0;
    endtask

    initial begin
        int          sent, recv, cyc;
        logic        pend, was_stalled;
        logic [21:0] prev_fields, got_fields, pend_fields;

        // Reset
        repeat (3) @(negedge clk);
        #1;
        check("rst_iss_valid", 32'(a_iss_valid), 32'd0);
        check("rst_id_ready",  32'(a_id_ready),  32'd1);
        check("rst_busy",      a_busy,           32'd0);
        check("rst_stall",     32'(a_stall),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        iss_ready = 1'b1;

        // 1: ADD x3,x1,x2 issues the cycle after acceptance, then writes back
        set_id(1, OP, 5'd3, 5'd1, 5'd2);
        #1 check("t1_id_ready", 32'(a_id_ready), 32'd1);
        step();
        set_id(0, '0, '0, '0, '0);
        #1;
        check("t1_iss_valid", 32'(a_iss_valid), 32'd1);
        check("t1_iss_rd",    32'(a_iss_rd),    32'd3);
        check("t1_busy_pre",  a_busy,           32'd0);
        step();
        check("t1_busy_set",  a_busy,           32'h8);
        check("t1_iss_empty", 32'(a_iss_valid), 32'd0);
        writeback(5'd3);
        #1 check("t1_busy_clr", a_busy, 32'd0);

        // 2: ADD x3 then SUB x4,x3,x1 stalls until x3 writes back
        set_id(1, OP, 5'd3, 5'd1, 5'd2);
        step();
        set_id(1, OP, 5'd4, 5'd3, 5'd1);
        #1;
        check("t2_add_valid", 32'(a_iss_valid), 32'd1);
        check("t2_id_ready",  32'(a_id_ready),  32'd1);
        step();
        set_id(0, '0, '0, '0, '0);
        #1;
        check("t2_sub_blocked",   32'(a_iss_valid), 32'd0);
        check("t2_sub_blocked_b", 32'(b_iss_valid), 32'd0);
        check("t2_id_ready_held", 32'(a_id_ready),  32'd0);
        check("t2_stall0",        32'(a_stall),     32'd0);
        step();
        check("t2_stall1", 32'(a_stall), 32'd1);
        step();
        check("t2_stall2",   32'(a_stall), 32'd2);
        check("t2_stall2_b", 32'(b_stall), 32'd2);
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        #1;
        check("t2_bypass_valid",   32'(a_iss_valid), 32'd1);
        check("t2_nobypass_valid", 32'(b_iss_valid), 32'd0);
        step();
        wb_valid = 1'b0;
        #1;
        check("t2_a_empty",   32'(a_iss_valid), 32'd0);
        check("t2_a_busy",    a_busy,           32'h10);
        check("t2_a_stall",   32'(a_stall),     32'd2);
        check("t2_b_valid",   32'(b_iss_valid), 32'd1);
        check("t2_b_rd",      32'(b_iss_rd),    32'd4);
        check("t2_b_stall",   32'(b_stall),     32'd3);
        check("t2_b_busy",    b_busy,           32'd0);
        step();
        check("t2_b_busy_set", b_busy, 32'h10);
        writeback(5'd4);
        #1;
        check("t2_a_busy_clr", a_busy, 32'd0);
        check("t2_b_busy_clr", b_busy, 32'd0);

        // 3: x0 never becomes busy or hazards; STORE never sets its rd field
        set_id(1, LUI, 5'd0, 5'd0, 5'd0);
        step();
        set_id(1, OP_IMM, 5'd5, 5'd0, 5'd1);
        #1 check("t3_lui_valid", 32'(a_iss_valid), 32'd1);
        step();
        set_id(1, STORE, 5'd7, 5'd1, 5'd2);
        #1;
        check("t3_addi_valid", 32'(a_iss_valid), 32'd1);
        check("t3_x0_busy",    a_busy,           32'd0);
        step();
        set_id(0, '0, '0, '0, '0);
        #1;
        check("t3_store_valid", 32'(a_iss_valid), 32'd1);
        check("t3_busy_x5",     a_busy,           32'h20);
        step();
        check("t3_store_no_set",   a_busy, 32'h20);
        check("t3_store_no_set_b", b_busy, 32'h20);
        writeback(5'd5);

        // 4: issue writing x6 alongside a writeback to x6: set wins
        set_id(1, OP, 5'd6, 5'd1, 5'd2);
        step();
        set_id(0, '0, '0, '0, '0);
        wb_valid = 1'b1;
        wb_rd    = 5'd6;
        #1 check("t4_valid", 32'(a_iss_valid), 32'd1);
        step();
        wb_valid = 1'b0;
        #1;
        check("t4_set_wins",   a_busy, 32'h40);
        check("t4_set_wins_b", b_busy, 32'h40);
        writeback(5'd6);
        #1 check("t4_clr", a_busy, 32'd0);

        // 5: flush a hazarded entry
        set_id(1, OP, 5'd3, 5'd1, 5'd2);
        step();
        set_id(1, OP, 5'd4, 5'd3, 5'd1);
        step();
        set_id(0, '0, '0, '0, '0);
        #1 check("t5_blocked", 32'(a_iss_valid), 32'd0);
        step();
        flush = 1'b1;
        set_id(1, OP, 5'd9, 5'd1, 5'd2);
        #1;
        check("t5_flush_id_ready",   32'(a_id_ready),  32'd0);
        check("t5_flush_id_ready_b", 32'(b_id_ready),  32'd0);
        check("t5_flush_no_issue",   32'(a_iss_valid), 32'd0);
        step();
        flush = 1'b0;
        set_id(0, '0, '0, '0, '0);
        #1;
        check("t5_entry_gone",  32'(a_iss_valid), 32'd0);
        check("t5_id_ready",    32'(a_id_ready),  32'd1);
        check("t5_busy_kept",   a_busy,           32'h8);
        check("t5_stall_a",     32'(a_stall),     32'd3);
        check("t5_stall_b",     32'(b_stall),     32'd4);
        step();
        check("t5_no_late_issue", 32'(a_iss_valid), 32'd0);
        writeback(5'd3);
        #1 check("t5_clr", a_busy, 32'd0);

        // 6: 100 independent instructions under random backpressure
        sent = 0;
        recv = 0;
        cyc  = 0;
        pend = 1'b0;
        was_stalled = 1'b0;
        prev_fields = '0;
        pend_fields = '0;
        while (recv < 100 && cyc < 3000) begin
            iss_ready = 1'($urandom_range(0, 1));
            if (!pend && sent < 100 && $urandom_range(0, 3) != 0) begin
                pend_fields = {($urandom_range(0, 1) != 0) ? STORE : BRANCH,
                               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                               5'($urandom_range(0, 31))};
                pend = 1'b1;
            end
            set_id(pend, pend_fields[21:15], pend_fields[14:10], pend_fields[9:5], pend_fields[4:0]);
            #1;
            got_fields = {a_iss_opcode, a_iss_rd, a_iss_rs1, a_iss_rs2};
            if (was_stalled) begin
                check("t6_hold_valid",  32'(a_iss_valid), 32'd1);
                check("t6_hold_fields", 32'(got_fields),  32'(prev_fields));
            end
            if (a_iss_valid && iss_ready) begin
                if (exp_q.size() == 0) begin
                    check("t6_unexpected_issue", 32'(got_fields), 32'hFFFF_FFFF);
                end else begin
                    check("t6_issue_fields", 32'(got_fields), 32'(exp_q.pop_front()));
                end
                recv++;
            end
            if (id_valid && a_id_ready) begin
                exp_q.push_back(pend_fields);
                sent++;
                pend = 1'b0;
            end
            was_stalled = a_iss_valid & ~iss_ready;
            prev_fields = got_fields;
            step();
            cyc++;
        end
        set_id(0, '0, '0, '0, '0);
        check("t6_received",   32'(recv),          32'd100);
        check("t6_queue_left", 32'(exp_q.size()),  32'd0);
        check("t6_busy",       a_busy,             32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
